// File: rtl/mips_pkg.sv
// Shared MIPS-I definitions: opcode/funct encodings, fetch state encoding and
// the branch-offset helper used by the next-PC logic.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [1:0] {
        ST_RST_WAIT = 2'd0,
        ST_FETCH    = 2'd1,
        ST_EXEC     = 2'd2
    } fetch_state_e;

    // Word offset of a beq: sign-extended imm16 scaled to bytes.
    function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
        return signed'({{14{imm[15]}}, imm, 2'b00});
    endfunction

endpackage

// File: rtl/ifu_pc_fetch_if.sv
// Instruction-memory fetch handshake; the fetch unit is master, memory is slave.
interface ifu_pc_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifu_npc_calc.sv
// Combinational next-PC selection: jump over taken branch over fall-through.
module ifu_npc_calc
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [25:0]       instr_idx_i,
    input  logic              branch_i,
    input  logic              zero_i,
    input  logic              jump_i,
    output logic [ADDR_W-1:0] npc_o
);

    logic [ADDR_W-1:0]        pc4;
    logic signed [ADDR_W-1:0] br_off;

    assign pc4    = pc_i + ADDR_W'(4);
    assign br_off = branch_offset(instr_idx_i[15:0]);

    always_comb begin
        npc_o = pc4;
        if (jump_i) begin
            npc_o = {pc4[ADDR_W-1:28], instr_idx_i, 2'b00};
        end else if (branch_i && zero_i) begin
            npc_o = pc4 + $unsigned(br_off);
        end
    end

endmodule

// File: rtl/ifu_pc_fetch.sv
// Instruction-fetch unit: holds the PC, fetches one word per instruction and
// retires it into the next PC, counting retired instructions.
module ifu_pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ifu_pc_fetch_if.master    imem,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instret
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] npc_d;
    logic [31:0]       instr_q;
    logic [31:0]       instret_q;
    logic              valid_q;
    logic              req_q;

    ifu_npc_calc #(
        .ADDR_W (ADDR_W)
    ) u_npc (
        .pc_i        (pc_q),
        .instr_idx_i (instr_q[25:0]),
        .branch_i    (branch),
        .zero_i      (zero),
        .jump_i      (jump),
        .npc_o       (npc_d)
    );

    // RST_WAIT keeps req low for one cycle so a late ack from an aborted fetch drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RST_WAIT;
            pc_q      <= ADDR_W'(RESET_PC);
            instr_q   <= '0;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            case (state_q)
                ST_RST_WAIT: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem.imem_ack && req_q) begin
                        instr_q <= imem.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc_q      <= npc_d;
                        instret_q <= instret_q + 32'd1;
                        valid_q   <= 1'b0;
                        req_q     <= 1'b1;
                        state_q   <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_RST_WAIT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[31:26];
    assign funct          = instr_q[5:0];
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Directed and randomized bench for ifu_pc_fetch against a behavioural PC/retire model.
module tb_ifu_pc_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch, zero, jump;
    logic [31:0] instr, pc, instret;
    logic [5:0]  opcode, funct;
    logic        instr_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_pc;
    logic [31:0] model_ret;
    logic [31:0] model_instr;

    ifu_pc_fetch_if #(.ADDR_W(32)) imem_bus ();

    ifu_pc_fetch #(.RESET_PC(32'h0000_3000), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus.master),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .instr       (instr),
        .opcode      (opcode),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] w,
                                              input logic br, input logic z, input logic jp);
        logic [31:0] pc4;
        int          imm;
        pc4 = p + 32'd4;
        if (jp) return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (br && z) begin
            imm = int'(w[15:0]);
            if (imm >= 32768) imm = imm - 65536;
            return pc4 + 32'(imm * 4);
        end
        return pc4;
    endfunction

    // Runs one instruction starting in FETCH: waits, ack, stalls, then retirement.
    task automatic do_instr(input logic [31:0] w, input int waits, input int stalls,
                            input logic br, input logic z, input logic jp);
        logic [31:0] w_op;
        check("req_at_fetch", {31'd0, imem_bus.imem_req}, 32'd1);
        check("addr_at_fetch", imem_bus.imem_addr, model_pc);
        for (int i = 0; i < waits; i++) begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = $urandom;
            branch = 1'($urandom); zero = 1'($urandom); jump = 1'($urandom); stall = 1'($urandom);
            step();
            check("wait_req", {31'd0, imem_bus.imem_req}, 32'd1);
            check("wait_addr", imem_bus.imem_addr, model_pc);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            check("wait_instr", instr, model_instr);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w;
        step();
        model_instr = w;
        w_op = w >> 26;
        check("cap_valid", {31'd0, instr_valid}, 32'd1);
        check("cap_instr", instr, w);
        check("cap_opcode", {26'd0, opcode}, w_op);
        check("cap_funct", {26'd0, funct}, w & 32'h3F);
        check("cap_req", {31'd0, imem_bus.imem_req}, 32'd0);
        branch = br; zero = z; jump = jp;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            imem_bus.imem_ack   = 1'($urandom);
            imem_bus.imem_rdata = $urandom;
            step();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_pc", pc, model_pc);
            check("stall_instr", instr, model_instr);
            check("stall_instret", instret, model_ret);
        end
        stall = 1'b0;
        imem_bus.imem_ack   = 1'($urandom);
        imem_bus.imem_rdata = $urandom;
        step();
        imem_bus.imem_ack = 1'b0;
        model_pc  = model_npc(model_pc, w, br, z, jp);
        model_ret = model_ret + 32'd1;
        check("ret_pc", pc, model_pc);
        check("ret_instret", instret, model_ret);
        check("ret_valid", {31'd0, instr_valid}, 32'd0);
        check("ret_instr", instr, model_instr);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
        model_pc = 32'h0000_3000; model_ret = 0; model_instr = 0;
        step();
        imem_bus.imem_ack = 1'b1;
        step();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check("rst_instret", instret, 32'h0);
        rst_n = 1'b1;
        step();
        imem_bus.imem_ack = 1'b0;
        check("first_addr", imem_bus.imem_addr, 32'h0000_3000);
        check("first_instr_still0", instr, 32'h0);

        do_instr(32'h3C01_1234, 0, 0, 1'b0, 1'b0, 1'b0);
        check("lui_opcode", {26'd0, opcode}, {26'd0, OP_LUI});
        check("lui_pc", pc, 32'h0000_3004);
        check("lui_instret", instret, 32'd1);

        do_instr(32'h0000_0021, 3, 0, 1'b0, 1'b0, 1'b0);
        check("delay_pc", pc, 32'h0000_3008);

        do_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0);
        check("beq_taken_pc", pc, 32'h0000_3004);
        do_instr(32'h0000_0021, 1, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0);
        check("beq_not_taken_pc", pc, 32'h0000_300C);
        do_instr(32'h0000_0021, 0, 0, 1'b0, 1'b0, 1'b0);
        check("pre_j_pc", pc, 32'h0000_3010);

        do_instr(32'h0800_0C00, 0, 5, 1'b1, 1'b1, 1'b1);
        check("j_wins_pc", pc, 32'h0000_3000);
        check("j_instret", instret, 32'd7);

        do_instr(32'h0800_0000, 0, 0, 1'b0, 1'b0, 1'b1);
        check("j_zero_pc", pc, 32'h0000_0000);
        do_instr(32'h1000_FFFF, 0, 1, 1'b1, 1'b1, 1'b0);
        check("beq_self_pc", pc, 32'h0000_0000);
        do_instr(32'h1000_FFFE, 2, 0, 1'b1, 1'b1, 1'b0);
        check("beq_neg_pc", pc, 32'hFFFF_FFFC);
        do_instr(32'h0000_0021, 0, 0, 1'b0, 1'b0, 1'b0);
        check("wrap_pc", pc, 32'h0000_0000);

        // Reset in FETCH while ack arrives, ack kept high through RST_WAIT.
        rst_n = 1'b0;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h3C01_FFFF;
        step();
        rst_n = 1'b1;
        check("midrst_instr", instr, 32'h0);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        imem_bus.imem_ack = 1'b0;
        check("post_rst_instr", instr, 32'h0);
        check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("post_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
        check("post_rst_addr", imem_bus.imem_addr, 32'h0000_3000);
        check("post_rst_instret", instret, 32'h0);
        model_pc = 32'h0000_3000; model_ret = 0; model_instr = 0;

        for (int n = 0; n < 24; n++) begin
            do_instr($urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                     1'($urandom), 1'($urandom), 1'($urandom_range(3, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifu_pc_fetch.md
Name: ifu_pc_fetch

Overview:
- Instruction-fetch unit for the single-cycle MIPS core. It holds the PC, fetches one word per instruction from instruction memory over a req/ack handshake, and presents the instruction (with opcode/funct split out) to the control decoder and datapath.
- It computes the next PC from the branch, jump and zero results of the current instruction when that instruction retires.
- It counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; must be word-aligned.
- ADDR_W, 32, PC/address width; fixed at 32 for MIPS-I; parameter kept for bench reuse.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  32  fetch address (= pc); stable while imem_req is high.
- imem_ack  in  1  imem_rdata is valid this cycle; honoured only in FETCH with imem_req high.
- imem_rdata  in  32  instruction word.
- instr  out  32  captured instruction.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- instr_valid  out  1  instr is valid and executing.
- pc  out  32  address of the current instruction.
- stall  in  1  datapath hold (e.g. slow dmem); blocks retirement.
- branch  in  1  current instruction is a conditional branch (beq).
- zero  in  1  ALU zero flag for the current instruction.
- jump  in  1  current instruction is j.
- instret  out  32  retired-instruction count; wraps.

Behaviour:
- Reset (rst_n low at the edge):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, instret=0, state=RST_WAIT.
  - Reset asserted mid-fetch or mid-execute aborts at that edge. Any later ack is ignored until FETCH is re-entered.
- States: RST_WAIT, FETCH, EXEC.
  - RST_WAIT: imem_req=0. Moves to FETCH unconditionally next cycle. This drains any in-flight ack.
  - FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
    - imem_ack=1: instr<=imem_rdata and go to EXEC.
    - Otherwise stay in FETCH. Unbounded wait; address held stable.
    - stall, branch, jump and zero are ignored.
  - EXEC: imem_req=0, instr_valid=1.
    - stall=1: hold everything.
    - stall=0: retire. pc<=npc, instret<=instret+1 (mod 2^32), go to FETCH.
    - imem_ack in EXEC is ignored.
- Latency: an ack in the same cycle as the request is legal. Minimum 2 cycles per instruction (1 FETCH + 1 EXEC). Each ack wait cycle and each stall cycle adds 1.
- Next PC (combinational, evaluated at retirement), with pc4 = pc+4 (32-bit wrap):
  - jump=1: npc = {pc4[31:28], instr[25:0], 2'b00}.
  - else branch=1 and zero=1: npc = pc4 + (sign_ext(instr[15:0]) << 2).
  - else: npc = pc4.
  - jump has priority over branch when both are asserted.
  - Taken branch with offset 16'hFFFF gives npc = pc.
  - pc=32'hFFFF_FFFC with fall-through gives npc = 0.
- pc[1:0] is always 2'b00 by construction; no misalignment path.
- opcode and funct are pure slices of instr. They are valid to consumers only while instr_valid=1.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_J=6'b000010, OP_BEQ=6'b000100, OP_LW, OP_SW, OP_ORI, OP_LUI)
  - funct constants (FN_ADDU, FN_SUBU)
  - fetch state enum
  - RESET_PC default
- One natural sub-module: ifu_npc_calc. It is combinational, takes pc, instr, branch, zero and jump, and produces npc. It can be unit-tested standalone.

Test Plan:
- Reset then ack on the first request cycle with rdata=32'h3C01_1234 (lui):
  - imem_addr=32'h0000_3000.
  - Next cycle instr_valid=1 and opcode=6'b001111.
  - With stall=0: pc=32'h0000_3004 and instret=1.
- Ack delayed 3 cycles:
  - imem_req stays high and imem_addr is stable for 4 cycles; instr is captured only on the ack cycle.
- beq at pc=32'h0000_3008 with imm16=16'hFFFE:
  - zero=1, branch=1 -> npc=32'h0000_3004.
  - zero=0 -> npc=32'h0000_300C.
- j at pc=32'h0000_3010 with instr=32'h0800_0C00 -> npc=32'h0000_3000.
  - With branch=1 and zero=1 also asserted, jump wins.
- stall=1 for 5 cycles in EXEC:
  - pc, instr and instret are unchanged and instr_valid stays 1.
  - Retirement happens on the first stall=0 cycle.
- rst_n low during FETCH while an ack arrives:
  - The ack is ignored and instr stays 0.
  - After RST_WAIT, a new request is issued at 32'h0000_3000 and instret=0.
